// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter.
// Two write clients share one registered register-file write port under
// alternating priority. An init pulse runs a 32-cycle clear sequence that
// zeroes every register and locks out the clients while it runs. Read data
// is forwarded from the write currently on the port so consumers never see
// a stale word.
`timescale 1ns/1ps

module regfile_wr_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,

    input  logic          c0_req,
    input  logic [4:0]    c0_addr,
    input  logic [DW-1:0] c0_data,
    output logic          c0_gnt,

    input  logic          c1_req,
    input  logic [4:0]    c1_addr,
    input  logic [DW-1:0] c1_data,
    output logic          c1_gnt,

    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,

    input  logic [4:0]    rd_addr1,
    input  logic [4:0]    rd_addr2,
    input  logic [DW-1:0] rf_rd_data1,
    input  logic [DW-1:0] rf_rd_data2,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,

    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;        // clear address
    logic          prio_q, prio_d;      // 0: client 0 wins a tie, 1: client 1
    logic          we_q, we_d;          // client write pending on the port
    logic [4:0]    waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          arb_ok;

    // State register: FSM, clear counter, priority and the captured client write.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, so ordering inside the block cannot matter.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: clear sequencing, priority hand-over and capture of the granted write.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (init) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // The counter wraps back to 0 as the last register is cleared.
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Grants only occur in IDLE, so this never overlaps a clear write.
        if (c0_gnt) begin
            prio_d  = 1'b1;
            we_d    = 1'b1;
            waddr_d = c0_addr;
            wdata_d = c0_data;
        end else if (c1_gnt) begin
            prio_d  = 1'b0;
            we_d    = 1'b1;
            waddr_d = c1_addr;
            wdata_d = c1_data;
        end
    end

    // Outputs: same-cycle grants, busy flag and the register-file write port.
    always_comb begin
        busy   = (state_q == CLEAR);
        arb_ok = (state_q == IDLE) && !init && !rst;
        c0_gnt = arb_ok && c0_req && (!c1_req || !prio_q);
        c1_gnt = arb_ok && c1_req && (!c0_req ||  prio_q);

        if (state_q == CLEAR) begin
            rf_we    = 1'b1;
            rf_waddr = cnt_q;
            rf_wdata = '0;
        end else begin
            rf_we    = we_q;
            rf_waddr = waddr_q;
            rf_wdata = wdata_q;
        end
    end

    // Read forwarding: each port independently bypasses the write on the port.
    always_comb begin
        rd_data1 = (rf_we && (rd_addr1 == rf_waddr)) ? rf_wdata : rf_rd_data1;
        rd_data2 = (rf_we && (rd_addr2 == rf_waddr)) ? rf_wdata : rf_rd_data2;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: a directed vector table,
// hand-written clear/abort sequences and a randomized run against a
// behavioural model of the arbitration and clear rules.
`timescale 1ns/1ps

module tb_regfile_wr_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          init;
    logic          c0_req, c1_req;
    logic [4:0]    c0_addr, c1_addr;
    logic [DW-1:0] c0_data, c1_data;
    logic          c0_gnt, c1_gnt;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [4:0]    rd_addr1, rd_addr2;
    logic [DW-1:0] rf_rd_data1, rf_rd_data2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wr_arbiter #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .c0_req      (c0_req),
        .c0_addr     (c0_addr),
        .c0_data     (c0_data),
        .c0_gnt      (c0_gnt),
        .c1_req      (c1_req),
        .c1_addr     (c1_addr),
        .c1_data     (c1_data),
        .c1_gnt      (c1_gnt),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst, init;
        logic          r0;
        logic [4:0]    a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic [4:0]    a1;
        logic [DW-1:0] d1;
        logic [4:0]    ra1, ra2;
        logic [DW-1:0] rr1, rr2;
        logic          eg0, eg1, ewe;
        logic [4:0]    ewa;
        logic [DW-1:0] ewd;
        logic          ebusy;
        logic [DW-1:0] ed1, ed2;
    } vec_t;

    function automatic vec_t mk(int rs, int in, int r0, int a0, int d0, int r1, int a1, int d1,
                                int ra1, int ra2, int rr1, int rr2,
                                int eg0, int eg1, int ewe, int ewa, int ewd, int ebusy,
                                int ed1, int ed2);
        vec_t v;
        v.rst = (rs != 0);   v.init = (in != 0);
        v.r0 = (r0 != 0);    v.a0 = 5'(a0);  v.d0 = 32'(d0);
        v.r1 = (r1 != 0);    v.a1 = 5'(a1);  v.d1 = 32'(d1);
        v.ra1 = 5'(ra1);     v.ra2 = 5'(ra2);
        v.rr1 = 32'(rr1);    v.rr2 = 32'(rr2);
        v.eg0 = (eg0 != 0);  v.eg1 = (eg1 != 0); v.ewe = (ewe != 0);
        v.ewa = 5'(ewa);     v.ewd = 32'(ewd);   v.ebusy = (ebusy != 0);
        v.ed1 = 32'(ed1);    v.ed2 = 32'(ed2);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic in,
                         input logic r0, input logic [4:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic [4:0] a1, input logic [DW-1:0] d1,
                         input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [DW-1:0] rr1, input logic [DW-1:0] rr2);
        rst = rs;  init = in;
        c0_req = r0; c0_addr = a0; c0_data = d0;
        c1_req = r1; c1_addr = a1; c1_data = d1;
        rd_addr1 = ra1; rd_addr2 = ra2;
        rf_rd_data1 = rr1; rf_rd_data2 = rr2;
    endtask

    task automatic check_outs(input string tag, input logic eg0, input logic eg1,
                              input logic ebusy, input logic ewe,
                              input logic [4:0] ewa, input logic [DW-1:0] ewd,
                              input logic [DW-1:0] ed1, input logic [DW-1:0] ed2);
        check({tag, " c0_gnt"},   64'(c0_gnt), 64'(eg0));
        check({tag, " c1_gnt"},   64'(c1_gnt), 64'(eg1));
        check({tag, " busy"},     64'(busy),   64'(ebusy));
        check({tag, " rf_we"},    64'(rf_we),  64'(ewe));
        if (ewe) begin
            check({tag, " rf_waddr"}, 64'(rf_waddr), 64'(ewa));
            check({tag, " rf_wdata"}, 64'(rf_wdata), 64'(ewd));
        end
        check({tag, " rd_data1"}, 64'(rd_data1), 64'(ed1));
        check({tag, " rd_data2"}, 64'(rd_data2), 64'(ed2));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: clear countdown, tie-break owner and the one pending client write.
    int            m_clear_left;
    int            m_prio;
    bit            m_pend;
    logic [4:0]    m_paddr;
    logic [DW-1:0] m_pdata;

    vec_t vecs[19];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        next_cycle();

        // Post-reset port state
        check("reset rf_we",    64'(rf_we),    64'd0);
        check("reset rf_waddr", 64'(rf_waddr), 64'd0);
        check("reset rf_wdata", 64'(rf_wdata), 64'd0);
        check("reset busy",     64'(busy),     64'd0);

        vecs[0]  = mk(1,0, 1,5,'hA5, 1,6,'hB6,  3,4,'h11,'h22,  0,0,0,0,0,0, 'h11,'h22);
        vecs[1]  = mk(0,0, 1,5,'hA5, 0,0,0,     5,5,'h33,'h44,  1,0,0,0,0,0, 'h33,'h44);
        vecs[2]  = mk(0,0, 0,0,0,    0,0,0,     5,6,'h55,'h66,  0,0,1,5,'hA5,0, 'hA5,'h66);
        vecs[3]  = mk(1,0, 0,0,0,    0,0,0,     5,6,'h77,'h88,  0,0,0,0,0,0, 'h77,'h88);
        vecs[4]  = mk(0,0, 1,10,'hC0000001, 1,11,'hC1000001, 0,1,1,2, 1,0,0,0,0,0, 1,2);
        vecs[5]  = mk(0,0, 1,10,'hC0000002, 1,11,'hC1000002, 0,1,1,2, 0,1,1,10,'hC0000001,0, 1,2);
        vecs[6]  = mk(0,0, 1,10,'hC0000003, 1,11,'hC1000003, 0,1,1,2, 1,0,1,11,'hC1000002,0, 1,2);
        vecs[7]  = mk(0,0, 1,10,'hC0000004, 1,11,'hC1000004, 0,1,1,2, 0,1,1,10,'hC0000003,0, 1,2);
        vecs[8]  = mk(0,0, 0,0,0, 0,0,0, 11,10,'h77,'h88, 0,0,1,11,'hC1000004,0, 'hC1000004,'h88);
        vecs[9]  = mk(0,0, 1,20,'hAAAA, 1,20,'hBBBB, 0,0,3,4, 1,0,0,0,0,0, 3,4);
        vecs[10] = mk(0,0, 0,0,0, 1,20,'hBBBB, 20,20,3,4, 0,1,1,20,'hAAAA,0, 'hAAAA,'hAAAA);
        vecs[11] = mk(0,0, 0,0,0, 0,0,0, 20,20,5,6, 0,0,1,20,'hBBBB,0, 'hBBBB,'hBBBB);
        vecs[12] = mk(0,0, 1,7,'h1234, 0,0,0, 7,7,9,9, 1,0,0,0,0,0, 9,9);
        vecs[13] = mk(0,0, 0,0,0, 0,0,0, 7,7,'hDEAD0001,'hDEAD0002, 0,0,1,7,'h1234,0, 'h1234,'h1234);
        vecs[14] = mk(0,0, 0,0,0, 0,0,0, 7,7,'hDEAD0001,'hDEAD0002, 0,0,0,0,0,0, 'hDEAD0001,'hDEAD0002);
        vecs[15] = mk(0,0, 0,0,0, 1,8,'h55, 7,8,1,2, 0,1,0,0,0,0, 1,2);
        vecs[16] = mk(0,0, 0,0,0, 0,0,0, 7,8,1,2, 0,0,1,8,'h55,0, 1,'h55);
        vecs[17] = mk(0,1, 0,0,0, 1,9,'h99, 9,9,1,2, 0,0,0,0,0,0, 1,2);
        vecs[18] = mk(0,0, 1,3,'h333, 1,9,'h99, 0,1,'hFFFF,'hEEEE, 0,0,1,0,0,1, 0,'hEEEE);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].init, vecs[i].r0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].a1, vecs[i].d1, vecs[i].ra1, vecs[i].ra2,
                  vecs[i].rr1, vecs[i].rr2);
            #3;
            check_outs($sformatf("row%0d", i), vecs[i].eg0, vecs[i].eg1, vecs[i].ebusy,
                       vecs[i].ewe, vecs[i].ewa, vecs[i].ewd, vecs[i].ed1, vecs[i].ed2);
            next_cycle();
        end

        // Remaining clear cycles: c0 held off, a stray init is ignored.
        for (int k = 1; k < 32; k++) begin
            drive(0, (k == 5), 1, 3, 'h333, 0, 0, 0, 5'(k), 5'(k + 1),
                  32'hFFFF_0000 | 32'(k), 32'h1234_0000 | 32'(k));
            #3;
            check_outs($sformatf("clear%0d", k), 0, 0, 1, 1, 5'(k), '0,
                       '0, 32'h1234_0000 | 32'(k));
            next_cycle();
        end
        drive(0, 0, 1, 3, 'h333, 0, 0, 0, 1, 2, 'h10, 'h20);
        #3;
        check_outs("after clear grant", 1, 0, 0, 0, 0, 0, 'h10, 'h20);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 'h10, 'h20);
        #3;
        check_outs("after clear write", 0, 0, 0, 1, 3, 'h333, 'h333, 'h20);
        next_cycle();

        // Reset in the 10th clear cycle aborts; a new init restarts at address 0.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h1, 'h2);
        #3;
        check_outs("abort init", 0, 0, 0, 0, 0, 0, 'h1, 'h2);
        next_cycle();
        for (int j = 0; j < 10; j++) begin
            drive((j == 9), 0, 1, 4, 'h44, 0, 0, 0, 5'(j), 5'(j), 'h1, 'h2);
            #3;
            check_outs($sformatf("abort clear%0d", j), 0, 0, 1, 1, 5'(j), '0, '0, '0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 10, 10, 'h1, 'h2);
        #3;
        check_outs("abort after rst", 0, 0, 0, 0, 0, 0, 'h1, 'h2);
        next_cycle();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h1, 'h2);
        #3;
        check_outs("restart init", 0, 0, 0, 0, 0, 0, 'h1, 'h2);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1, 'h2);
        #3;
        check_outs("restart clear0", 0, 0, 1, 1, 0, '0, '0, 'h2);
        next_cycle();

        // Randomized run against the model, starting from reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        m_clear_left = 0;
        m_prio       = 0;
        m_pend       = 1'b0;
        m_paddr      = '0;
        m_pdata      = '0;
        for (int i = 0; i < 3000; i++) begin
            logic          rs, in, q0, q1, e_busy, e_we, e_g0, e_g1;
            logic [4:0]    a0, a1, ra1, ra2, e_wa;
            logic [DW-1:0] d0, d1, rr1, rr2, e_wd, e_d1, e_d2;
            int            winner;

            e_busy = (m_clear_left > 0);
            if (e_busy) begin
                e_we = 1'b1;
                e_wa = 5'(32 - m_clear_left);
                e_wd = '0;
            end else begin
                e_we = m_pend;
                e_wa = m_paddr;
                e_wd = m_pdata;
            end

            rs  = ($urandom_range(0, 63) == 0);
            in  = ($urandom_range(0, 19) == 0);
            q0  = 1'($urandom_range(0, 1));
            q1  = 1'($urandom_range(0, 1));
            a0  = 5'($urandom_range(0, 31));
            a1  = 5'($urandom_range(0, 31));
            d0  = $urandom;
            d1  = $urandom;
            ra1 = ($urandom_range(0, 2) == 0) ? e_wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? e_wa : 5'($urandom_range(0, 31));
            rr1 = $urandom;
            rr2 = $urandom;

            winner = -1;
            if (!rs && !e_busy && !in) begin
                if (q0 && q1)  winner = m_prio;
                else if (q0)   winner = 0;
                else if (q1)   winner = 1;
            end
            e_g0 = (winner == 0);
            e_g1 = (winner == 1);
            e_d1 = (e_we && ra1 == e_wa) ? e_wd : rr1;
            e_d2 = (e_we && ra2 == e_wa) ? e_wd : rr2;

            drive(rs, in, q0, a0, d0, q1, a1, d1, ra1, ra2, rr1, rr2);
            #3;
            check_outs($sformatf("rand%0d", i), e_g0, e_g1, e_busy, e_we, e_wa, e_wd, e_d1, e_d2);

            if (rs) begin
                m_clear_left = 0;
                m_prio       = 0;
                m_pend       = 1'b0;
                m_paddr      = '0;
                m_pdata      = '0;
            end else if (e_busy) begin
                m_clear_left--;
                m_pend = 1'b0;
            end else if (in) begin
                m_clear_left = 32;
                m_pend       = 1'b0;
            end else if (winner >= 0) begin
                m_pend  = 1'b1;
                m_paddr = (winner == 0) ? a0 : a1;
                m_pdata = (winner == 0) ? d0 : d1;
                m_prio  = 1 - winner;
            end else begin
                m_pend = 1'b0;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
